// File: rtl/btb_pkg.sv
// Shared constants and helpers for the set-associative branch target buffer.
package btb_pkg;

   localparam int unsigned DefSets         = 32;
   localparam int unsigned DefWays         = 2;
   localparam int unsigned DefTargetWidth  = 32;
   localparam int unsigned DefCounterWidth = 2;
   localparam int unsigned MaxCounterWidth = 4;

   // Saturating up/down counter step; cnt is zero-extended from a cw-bit counter.
   function automatic logic [MaxCounterWidth-1:0] sat_next(
      input logic [MaxCounterWidth-1:0] cnt,
      input logic                       taken,
      input int unsigned                cw
   );
      logic [MaxCounterWidth-1:0] max_val;
      max_val = MaxCounterWidth'((32'd1 << cw) - 32'd1);
      if (taken) begin
         return (cnt == max_val) ? cnt : cnt + 4'd1;
      end
      return (cnt == '0) ? cnt : cnt - 4'd1;
   endfunction

endpackage

// File: rtl/btb_victim_sel.sv
// Picks the allocation way: lowest invalid way, else the set's round-robin pointer.
module btb_victim_sel #(
   parameter int unsigned WAYS  = 2,
   parameter int unsigned PTR_W = 1
) (
   input  logic [WAYS-1:0]  valid_i,
   input  logic [PTR_W-1:0] ptr_i,
   output logic [PTR_W-1:0] victim_o
);

   always_comb begin
      victim_o = ptr_i;
      for (int w = int'(WAYS) - 1; w >= 0; w--) begin
         if (!valid_i[w]) victim_o = PTR_W'(w);
      end
   end

endmodule

// File: rtl/btb_assoc_predictor.sv
// Set-associative BTB with per-entry saturating direction counters, flip-flop storage,
// combinational fetch lookup and single-cycle flush.
module btb_assoc_predictor
   import btb_pkg::*;
#(
   parameter int unsigned SETS          = DefSets,
   parameter int unsigned WAYS          = DefWays,
   parameter int unsigned TARGET_WIDTH  = DefTargetWidth,
   parameter int unsigned COUNTER_WIDTH = DefCounterWidth
) (
   input  logic                    clk_i,
   input  logic                    rst_i,
   input  logic [31:0]             fetchPc_i,
   output logic                    fetchHit_o,
   output logic [TARGET_WIDTH-1:0] fetchTarget_o,
   input  logic                    exValid_i,
   input  logic [31:0]             exPc_i,
   input  logic                    exTaken_i,
   input  logic [TARGET_WIDTH-1:0] exTarget_i,
   input  logic                    flush_i
);

   localparam int unsigned IDX_W = $clog2(SETS);
   localparam int unsigned TAG_W = 31 - IDX_W;
   localparam int unsigned PTR_W = (WAYS > 1) ? $clog2(WAYS) : 1;
   localparam logic [COUNTER_WIDTH-1:0] CtrWeakTaken = COUNTER_WIDTH'(1) << (COUNTER_WIDTH - 1);

   logic [WAYS-1:0]          valid_q  [SETS];
   logic [WAYS-1:0]          valid_d  [SETS];
   logic [TAG_W-1:0]         tag_q    [SETS][WAYS];
   logic [TAG_W-1:0]         tag_d    [SETS][WAYS];
   logic [TARGET_WIDTH-1:0]  target_q [SETS][WAYS];
   logic [TARGET_WIDTH-1:0]  target_d [SETS][WAYS];
   logic [COUNTER_WIDTH-1:0] ctr_q    [SETS][WAYS];
   logic [COUNTER_WIDTH-1:0] ctr_d    [SETS][WAYS];
   logic [PTR_W-1:0]         ptr_q    [SETS];
   logic [PTR_W-1:0]         ptr_d    [SETS];

   logic [IDX_W-1:0] f_idx, e_idx;
   logic [TAG_W-1:0] f_tag, e_tag;
   logic             f_hit, e_hit;
   logic [PTR_W-1:0] f_way, e_way, e_victim;
   logic             unused_pc_lsb;

   assign f_idx         = fetchPc_i[IDX_W:1];
   assign f_tag         = fetchPc_i[31:IDX_W+1];
   assign e_idx         = exPc_i[IDX_W:1];
   assign e_tag         = exPc_i[31:IDX_W+1];
   assign unused_pc_lsb = fetchPc_i[0] ^ exPc_i[0];

   always_comb begin
      f_hit = 1'b0;
      f_way = '0;
      e_hit = 1'b0;
      e_way = '0;
      for (int w = 0; w < int'(WAYS); w++) begin
         if (valid_q[f_idx][w] && tag_q[f_idx][w] == f_tag) begin
            f_hit = 1'b1;
            f_way = PTR_W'(w);
         end
         if (valid_q[e_idx][w] && tag_q[e_idx][w] == e_tag) begin
            e_hit = 1'b1;
            e_way = PTR_W'(w);
         end
      end
   end

   // Outputs read pre-update state: no bypass from a same-cycle update.
   always_comb begin
      fetchHit_o    = f_hit && ctr_q[f_idx][f_way][COUNTER_WIDTH-1];
      fetchTarget_o = fetchHit_o ? target_q[f_idx][f_way] : '0;
   end

   btb_victim_sel #(
      .WAYS  (WAYS),
      .PTR_W (PTR_W)
   ) u_victim_sel (
      .valid_i  (valid_q[e_idx]),
      .ptr_i    (ptr_q[e_idx]),
      .victim_o (e_victim)
   );

   always_comb begin
      valid_d  = valid_q;
      tag_d    = tag_q;
      target_d = target_q;
      ctr_d    = ctr_q;
      ptr_d    = ptr_q;
      if (flush_i) begin
         for (int s = 0; s < int'(SETS); s++) begin
            valid_d[s] = '0;
            ptr_d[s]   = '0;
         end
      end else if (exValid_i) begin
         if (e_hit) begin
            ctr_d[e_idx][e_way] = COUNTER_WIDTH'(sat_next(MaxCounterWidth'(ctr_q[e_idx][e_way]),
                                                          exTaken_i, COUNTER_WIDTH));
            if (exTaken_i) target_d[e_idx][e_way] = exTarget_i;
         end else if (exTaken_i) begin
            valid_d[e_idx][e_victim]  = 1'b1;
            tag_d[e_idx][e_victim]    = e_tag;
            target_d[e_idx][e_victim] = exTarget_i;
            ctr_d[e_idx][e_victim]    = CtrWeakTaken;
            // Pointer only moves when an allocation had to evict.
            if (&valid_q[e_idx]) begin
               ptr_d[e_idx] = (ptr_q[e_idx] == PTR_W'(WAYS - 1)) ? '0 : ptr_q[e_idx] + PTR_W'(1);
            end
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         for (int s = 0; s < int'(SETS); s++) begin
            valid_q[s] <= '0;
            ptr_q[s]   <= '0;
            for (int w = 0; w < int'(WAYS); w++) ctr_q[s][w] <= '0;
         end
      end else begin
         valid_q <= valid_d;
         ctr_q   <= ctr_d;
         ptr_q   <= ptr_d;
      end
   end

   // Tags and targets need no reset: they are ignored while the way is invalid.
   always_ff @(posedge clk_i) begin
      tag_q    <= tag_d;
      target_q <= target_d;
   end

endmodule
